// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard / stall controller. Tracks in-flight writers
//                (DX, XM, MW) in a small scoreboard, raises RAW stalls,
//                handles branch redirects, memory freezes and HALT draining.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int unsigned FORWARDING = 1,
  parameter int unsigned WB_BYPASS  = 1,
  parameter int unsigned DRAIN      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [2:0]  readRegSel1,
  input  logic [2:0]  readRegSel2,
  input  logic        r1_hdu,
  input  logic        r2_hdu,
  input  logic [2:0]  writeRegSel,
  input  logic        regWrite,
  input  logic        memRead,
  input  logic        HALT,
  input  logic        branch_taken,
  input  logic        mem_stall,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_en,
  output logic        id_ex_bubble,
  output logic        halted,
  output logic [15:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic       rw;
    logic       mr;
    logic [2:0] dest;
  } sb_t;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [2:0]  C_DRAIN_LAST = 3'(DRAIN - 1);
  localparam logic [15:0] C_CNT_MAX    = 16'hFFFF;

  state_t      state_q, state_d;
  sb_t         x_q, m_q, w_q;
  sb_t         x_d, m_d, w_d;
  logic [2:0]  drain_q, drain_d;
  logic [15:0] cnt_q, cnt_d;

  logic w_match_x, w_match_m, w_match_w, w_hz;

  // RAW check of the decode-stage sources against one in-flight writer; r0 is a real register
  function automatic logic match_e(input sb_t e, input logic vld,
                                   input logic u1, input logic [2:0] s1,
                                   input logic u2, input logic [2:0] s2);
    return e.valid & e.rw & vld & ((u1 & (s1 == e.dest)) | (u2 & (s2 == e.dest)));
  endfunction

  assign w_match_x = match_e(x_q, id_valid, r1_hdu, readRegSel1, r2_hdu, readRegSel2);
  assign w_match_m = match_e(m_q, id_valid, r1_hdu, readRegSel1, r2_hdu, readRegSel2);
  assign w_match_w = match_e(w_q, id_valid, r1_hdu, readRegSel1, r2_hdu, readRegSel2);

  // With forwarding only a load in EX cannot be bypassed in time
  assign w_hz = (FORWARDING != 0) ? (w_match_x & x_q.mr)
              : (w_match_x | w_match_m | ((WB_BYPASS == 0) & w_match_w));

  assign halted      = (state_q == S_HALTED);
  assign stall_count = cnt_q;

  // Control outputs, scoreboard shift, FSM and counter next-state
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b0;
    id_ex_bubble = 1'b0;
    state_d      = state_q;
    drain_d      = drain_q;
    cnt_d        = cnt_q;
    x_d          = x_q;
    m_d          = m_q;
    w_d          = w_q;

    // Reset and memory freeze both force every enable low and hold all state
    if (rst && !mem_stall) begin
      case (state_q)
        S_RUN: begin
          if (branch_taken) begin
            pc_en        = 1'b1;
            if_id_en     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_en     = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (w_hz) begin
            id_ex_en     = 1'b1;
            id_ex_bubble = 1'b1;
            if (cnt_q != C_CNT_MAX) cnt_d = cnt_q + 16'd1;
          end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
            id_ex_en = 1'b1;
            if (HALT && id_valid) begin
              state_d = S_DRAIN;
              drain_d = 3'd0;
            end
          end
        end
        S_DRAIN: begin
          id_ex_en     = 1'b1;
          id_ex_bubble = 1'b1;
          if (drain_q == C_DRAIN_LAST) state_d = S_HALTED;
          else                         drain_d = drain_q + 3'd1;
        end
        default: begin
          state_d = S_HALTED;
        end
      endcase

      w_d = m_q;
      m_d = x_q;
      x_d = '{valid: id_valid & id_ex_en & ~id_ex_bubble,
              rw:    regWrite,
              mr:    memRead,
              dest:  writeRegSel};
    end
  end

  // State, scoreboard and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      x_q     <= '0;
      m_q     <= '0;
      w_q     <= '0;
      drain_q <= 3'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      m_q     <= m_d;
      w_q     <= w_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Directed bench for hazard_ctrl; one forwarding and one
//                non-forwarding instance share the same decode stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_valid, r1_hdu, r2_hdu, regWrite, memRead, HALT, branch_taken, mem_stall;
  logic [2:0] readRegSel1, readRegSel2, writeRegSel;

  logic a_pc, a_ifid, a_fl, a_idex, a_bub, a_hlt;
  logic b_pc, b_ifid, b_fl, b_idex, b_bub, b_hlt;
  logic [15:0] a_cnt, b_cnt;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, halted}
  localparam logic [5:0] O_RUN    = 6'b110100;
  localparam logic [5:0] O_STALL  = 6'b000110;
  localparam logic [5:0] O_BR     = 6'b111110;
  localparam logic [5:0] O_FRZ    = 6'b000000;
  localparam logic [5:0] O_HALTED = 6'b000001;

  typedef struct {
    string       tag;
    bit          sel;
    logic [5:0]  ov;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.FORWARDING(1), .WB_BYPASS(1), .DRAIN(3)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .readRegSel1(readRegSel1), .readRegSel2(readRegSel2),
    .r1_hdu(r1_hdu), .r2_hdu(r2_hdu), .writeRegSel(writeRegSel),
    .regWrite(regWrite), .memRead(memRead), .HALT(HALT),
    .branch_taken(branch_taken), .mem_stall(mem_stall),
    .pc_en(a_pc), .if_id_en(a_ifid), .if_id_flush(a_fl), .id_ex_en(a_idex),
    .id_ex_bubble(a_bub), .halted(a_hlt), .stall_count(a_cnt)
  );

  hazard_ctrl #(.FORWARDING(0), .WB_BYPASS(1), .DRAIN(3)) u_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .readRegSel1(readRegSel1), .readRegSel2(readRegSel2),
    .r1_hdu(r1_hdu), .r2_hdu(r2_hdu), .writeRegSel(writeRegSel),
    .regWrite(regWrite), .memRead(memRead), .HALT(HALT),
    .branch_taken(branch_taken), .mem_stall(mem_stall),
    .pc_en(b_pc), .if_id_en(b_ifid), .if_id_flush(b_fl), .id_ex_en(b_idex),
    .id_ex_bubble(b_bub), .halted(b_hlt), .stall_count(b_cnt)
  );

  task automatic set_id(input logic v, input logic [2:0] s1, input logic [2:0] s2,
                        input logic u1, input logic u2, input logic [2:0] wd,
                        input logic rw, input logic mr, input logic hlt);
    id_valid = v;  readRegSel1 = s1; readRegSel2 = s2;
    r1_hdu = u1;   r2_hdu = u2;      writeRegSel = wd;
    regWrite = rw; memRead = mr;     HALT = hlt;
  endtask

  task automatic nop_id();
    set_id(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input string tag, input logic [5:0] oa, input logic [15:0] ca,
                      input logic [5:0] ob, input logic [15:0] cb);
    q.push_back('{tag: tag, sel: 1'b0, ov: oa, cnt: ca});
    q.push_back('{tag: tag, sel: 1'b1, ov: ob, cnt: cb});
  endtask

  task automatic cmp(input exp_t e);
    logic [5:0]  ov;
    logic [15:0] oc;
    if (e.sel) begin
      ov = {b_pc, b_ifid, b_fl, b_idex, b_bub, b_hlt};
      oc = b_cnt;
    end else begin
      ov = {a_pc, a_ifid, a_fl, a_idex, a_bub, a_hlt};
      oc = a_cnt;
    end
    n_total++;
    assert (ov === e.ov) else begin
      n_bad++;
      $error("FAIL %s.ctl dut=%0d observed=%b expected=%b", e.tag, e.sel, ov, e.ov);
    end
    n_total++;
    assert (oc === e.cnt) else begin
      n_bad++;
      $error("FAIL %s.cnt dut=%0d observed=%0d expected=%0d", e.tag, e.sel, oc, e.cnt);
    end
  endtask

  task automatic check_q();
    while (q.size() > 0) cmp(q.pop_front());
  endtask

  task automatic tick();
    @(negedge clk);
    check_q();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [15:0] ca, input logic [15:0] cb);
    for (int i = 0; i < n; i++) begin
      nop_id();
      push("idle", O_RUN, ca, O_RUN, cb);
      tick();
    end
  endtask

  initial begin
    nop_id();
    branch_taken = 1'b0;
    mem_stall    = 1'b0;

    // Reset state
    #3;
    push("reset", O_FRZ, 16'd0, O_FRZ, 16'd0);
    check_q();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // T1: load r3 then a reader of r3
    set_id(1, 3'd0, 3'd0, 0, 0, 3'd3, 1, 1, 0);
    push("t1_load", O_RUN, 16'd0, O_RUN, 16'd0);   tick();
    set_id(1, 3'd3, 3'd0, 1, 0, 3'd4, 1, 0, 0);
    push("t1_use", O_STALL, 16'd0, O_STALL, 16'd0); tick();
    push("t1_rel", O_RUN, 16'd1, O_STALL, 16'd1);   tick();
    nop_id();
    push("t1_after", O_RUN, 16'd1, O_RUN, 16'd2);   tick();
    idle(2, 16'd1, 16'd2);

    // T2: ALU writer r2, reader through source 2
    set_id(1, 3'd0, 3'd0, 0, 0, 3'd2, 1, 0, 0);
    push("t2_add", O_RUN, 16'd1, O_RUN, 16'd2);     tick();
    set_id(1, 3'd5, 3'd2, 0, 1, 3'd6, 1, 0, 0);
    push("t2_s1", O_RUN, 16'd1, O_STALL, 16'd2);    tick();
    push("t2_s2", O_RUN, 16'd1, O_STALL, 16'd3);    tick();
    push("t2_rel", O_RUN, 16'd1, O_RUN, 16'd4);     tick();
    idle(3, 16'd1, 16'd4);

    // Matching selects without used flags never stall
    set_id(1, 3'd0, 3'd0, 0, 0, 3'd2, 1, 1, 0);
    push("gate_ld", O_RUN, 16'd1, O_RUN, 16'd4);    tick();
    set_id(1, 3'd2, 3'd2, 0, 0, 3'd6, 1, 0, 0);
    push("gate_rd", O_RUN, 16'd1, O_RUN, 16'd4);    tick();
    idle(3, 16'd1, 16'd4);

    // r0 is a real destination
    set_id(1, 3'd0, 3'd0, 0, 0, 3'd0, 1, 1, 0);
    push("r0_ld", O_RUN, 16'd1, O_RUN, 16'd4);      tick();
    set_id(1, 3'd7, 3'd0, 0, 1, 3'd5, 1, 0, 0);
    push("r0_use", O_STALL, 16'd1, O_STALL, 16'd4); tick();
    push("r0_rel", O_RUN, 16'd2, O_STALL, 16'd5);   tick();
    nop_id();
    push("r0_after", O_RUN, 16'd2, O_RUN, 16'd6);   tick();
    idle(2, 16'd2, 16'd6);

    // T3: load-use coincident with a taken branch
    set_id(1, 3'd0, 3'd0, 0, 0, 3'd3, 1, 1, 0);
    push("t3_load", O_RUN, 16'd2, O_RUN, 16'd6);    tick();
    set_id(1, 3'd3, 3'd0, 1, 0, 3'd4, 1, 0, 0);
    branch_taken = 1'b1;
    push("t3_br", O_BR, 16'd2, O_BR, 16'd6);        tick();
    branch_taken = 1'b0;
    nop_id();
    push("t3_after", O_RUN, 16'd2, O_RUN, 16'd6);   tick();
    idle(2, 16'd2, 16'd6);

    // T4: load-use frozen by memory for 4 cycles
    set_id(1, 3'd0, 3'd0, 0, 0, 3'd3, 1, 1, 0);
    push("t4_load", O_RUN, 16'd2, O_RUN, 16'd6);    tick();
    set_id(1, 3'd3, 3'd0, 1, 0, 3'd4, 1, 0, 0);
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push("t4_frz", O_FRZ, 16'd2, O_FRZ, 16'd6);   tick();
    end
    mem_stall = 1'b0;
    push("t4_use", O_STALL, 16'd2, O_STALL, 16'd6); tick();
    push("t4_rel", O_RUN, 16'd3, O_STALL, 16'd7);   tick();
    nop_id();
    push("t4_after", O_RUN, 16'd3, O_RUN, 16'd8);   tick();
    idle(2, 16'd3, 16'd8);

    // T5: HALT drain, branch ignored mid-drain
    set_id(1, 3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 1);
    push("t5_halt", O_RUN, 16'd3, O_RUN, 16'd8);    tick();
    nop_id();
    push("t5_d1", O_STALL, 16'd3, O_STALL, 16'd8);  tick();
    branch_taken = 1'b1;
    push("t5_d2", O_STALL, 16'd3, O_STALL, 16'd8);  tick();
    branch_taken = 1'b0;
    push("t5_d3", O_STALL, 16'd3, O_STALL, 16'd8);  tick();
    push("t5_h1", O_HALTED, 16'd3, O_HALTED, 16'd8); tick();
    push("t5_h2", O_HALTED, 16'd3, O_HALTED, 16'd8); tick();

    // T6: asynchronous reset in the middle of a stall
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    set_id(1, 3'd0, 3'd0, 0, 0, 3'd3, 1, 1, 0);
    push("t6_load", O_RUN, 16'd0, O_RUN, 16'd0);    tick();
    set_id(1, 3'd3, 3'd0, 1, 0, 3'd4, 1, 0, 0);
    push("t6_use", O_STALL, 16'd0, O_STALL, 16'd0); tick();
    push("t6_mid", O_RUN, 16'd1, O_STALL, 16'd1);
    @(negedge clk);
    check_q();
    #2;
    rst = 1'b0;
    #1;
    push("t6_async", O_FRZ, 16'd0, O_FRZ, 16'd0);
    check_q();
    @(posedge clk);
    #1;
    push("t6_hold", O_FRZ, 16'd0, O_FRZ, 16'd0);
    check_q();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push("t6_first", O_RUN, 16'd0, O_RUN, 16'd0);   tick();
    nop_id();
    push("t6_after", O_RUN, 16'd0, O_RUN, 16'd0);   tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
